// File: rtl/management_bus_arbiter_pkg.sv
// Shared definitions for the two-master management bus arbiter.
package management_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } mgmt_state_t;

    // Read data returned when the register interface never answers.
    localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

    // Master index to one-hot response/grant vector.
    function automatic logic [1:0] master_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/management_bus_arbiter_rr.sv
// Two-way round-robin grant with a last-grant pointer that only moves on an accepted transfer.
module mgmt_rr_arbiter_2
    import management_bus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       grant_idx,
    output logic       accept
);

    logic last_q;

    // Pick the winner: with both requesting, the master not granted last wins.
    always_comb begin
        grant_idx = 1'b0;
        grant     = '0;
        if (req == 2'b11) begin
            grant_idx = ~last_q;
        end else begin
            grant_idx = req[1];
        end
        if (enable && (req != 2'b00)) begin
            grant = master_onehot(grant_idx);
        end
        accept = |(req & grant);
    end

    // Pointer resets to master 1 so master 0 is favoured first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/management_bus_arbiter.sv
// Arbitrates two masters onto a single-outstanding management register interface.
module management_bus_arbiter
    import management_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  m_req_valid,
    output logic [1:0]  m_req_ready,
    input  logic [1:0]  m_req_write,
    input  logic [31:0] m_req_addr,
    input  logic [15:0] m_req_wdata,
    output logic [1:0]  m_rsp_valid,
    output logic        m_rsp_err,
    output logic [7:0]  m_rsp_data,
    output logic        mgmt_rd_en,
    output logic [15:0] mgmt_rd_addr,
    input  logic        mgmt_rd_valid,
    input  logic [7:0]  mgmt_rd_data,
    output logic        mgmt_wr_en,
    output logic [15:0] mgmt_wr_addr,
    output logic [7:0]  mgmt_wr_data
);

    // The counter is 0 in the first wait cycle; seeing TIMEOUT_CYCLES-2 with no
    // answer means it is about to reach TIMEOUT_CYCLES-1, so the response lands
    // TIMEOUT_CYCLES cycles after the read strobe.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 2);

    mgmt_state_t state;
    logic        owner;
    logic        is_write;
    logic [7:0]  cnt;
    logic [1:0]  grant;
    logic        grant_idx;
    logic        accept;

    mgmt_rr_arbiter_2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (m_req_valid),
        .enable    (state == ST_IDLE),
        .grant     (grant),
        .grant_idx (grant_idx),
        .accept    (accept)
    );

    assign m_req_ready = grant;

    // Transaction FSM with registered strobes and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            owner        <= 1'b0;
            is_write     <= 1'b0;
            cnt          <= '0;
            mgmt_rd_en   <= 1'b0;
            mgmt_wr_en   <= 1'b0;
            mgmt_rd_addr <= '0;
            mgmt_wr_addr <= '0;
            mgmt_wr_data <= '0;
            m_rsp_valid  <= '0;
            m_rsp_err    <= 1'b0;
            m_rsp_data   <= '0;
        end else begin
            mgmt_rd_en  <= 1'b0;
            mgmt_wr_en  <= 1'b0;
            m_rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner    <= grant_idx;
                        is_write <= m_req_write[grant_idx];
                        if (m_req_write[grant_idx]) begin
                            mgmt_wr_en   <= 1'b1;
                            mgmt_wr_addr <= grant_idx ? m_req_addr[31:16] : m_req_addr[15:0];
                            mgmt_wr_data <= grant_idx ? m_req_wdata[15:8] : m_req_wdata[7:0];
                        end else begin
                            mgmt_rd_en   <= 1'b1;
                            mgmt_rd_addr <= grant_idx ? m_req_addr[31:16] : m_req_addr[15:0];
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (is_write) begin
                        m_rsp_valid <= master_onehot(owner);
                        m_rsp_data  <= '0;
                        m_rsp_err   <= 1'b0;
                        state       <= ST_RESP;
                    end else begin
                        cnt   <= '0;
                        state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (mgmt_rd_valid) begin
                        m_rsp_valid <= master_onehot(owner);
                        m_rsp_data  <= mgmt_rd_data;
                        m_rsp_err   <= 1'b0;
                        state       <= ST_RESP;
                    end else if (cnt == CNT_LAST) begin
                        cnt         <= cnt + 8'd1;
                        m_rsp_valid <= master_onehot(owner);
                        m_rsp_data  <= TIMEOUT_DATA;
                        m_rsp_err   <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/management_bus_arbiter.md
MANAGEMENT_BUS_ARBITER -- requirements
Module: management_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: max cycles from mgmt_rd_en to mgmt_rd_valid before abort; legal range 2..255.
REQ-002 SHALL have port clk, input, 1: single clock for all logic; same domain as the management register interface.
REQ-003 SHALL have port rst, input, 1: reset, synchronous to clk, active high.
REQ-004 SHALL have port m_req_valid, input, 2: per-master request strobe; bit i belongs to master i.
REQ-005 SHALL have port m_req_ready, output, 2: per-master accept; a transfer occurs when valid and ready are both high.
REQ-006 SHALL have port m_req_write, input, 2: 1 = write, 0 = read.
REQ-007 SHALL have port m_req_addr, input, 32: two packed 16-bit addresses; master i uses bits [16i+15:16i].
REQ-008 SHALL have port m_req_wdata, input, 16: two packed 8-bit write data values.
REQ-009 SHALL have port m_rsp_valid, output, 2: one-cycle completion pulse to the owning master.
REQ-010 SHALL have port m_rsp_err, output, 1: qualifies m_rsp_valid; 1 = read timed out.
REQ-011 SHALL have port m_rsp_data, output, 8: read data, shared by both masters; 0x00 on writes.
REQ-012 SHALL have port mgmt_rd_en, output, 1: read strobe to the register interface.
REQ-013 SHALL have port mgmt_rd_addr, output, 16: read address.
REQ-014 SHALL have port mgmt_rd_valid, input, 1: read data valid from the register interface.
REQ-015 SHALL have port mgmt_rd_data, input, 8: read data.
REQ-016 SHALL have port mgmt_wr_en, output, 1: write strobe.
REQ-017 SHALL have port mgmt_wr_addr, output, 16: write address.
REQ-018 SHALL have port mgmt_wr_data, output, 8: write data.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, RD_WAIT, RESP.
REQ-020 In IDLE, SHALL assert m_req_ready only to the granted master, combinationally from m_req_valid and the last-grant pointer; all other ready bits SHALL be 0.
REQ-021 Arbitration SHALL be round robin; with both masters requesting, the master not granted last wins; the pointer SHALL update only on an accepted transfer.
REQ-022 On accept, SHALL latch owner, write flag, address and data, then go to ISSUE.
REQ-023 In ISSUE, SHALL pulse mgmt_wr_en or mgmt_rd_en for exactly one cycle with the latched address/data; write goes to RESP, read goes to RD_WAIT with timeout counter cleared.
REQ-024 In RD_WAIT, mgmt_rd_valid SHALL latch mgmt_rd_data and go to RESP; otherwise the counter increments.
REQ-025 When the counter reaches TIMEOUT_CYCLES-1 without mgmt_rd_valid, SHALL go to RESP with data 0xFF and err 1.
REQ-026 In RESP, SHALL pulse m_rsp_valid[owner] for one cycle with m_rsp_data/m_rsp_err, then return to IDLE.
REQ-027 Latency SHALL be: write accept at cycle N gives mgmt_wr_en at N+1 and m_rsp_valid at N+2; read gives mgmt_rd_en at N+1 and m_rsp_valid one cycle after mgmt_rd_valid.
REQ-028 Only one transaction SHALL be outstanding; m_req_ready SHALL be 0 in all states except IDLE.
REQ-029 mgmt_rd_valid outside RD_WAIT, including a late response after timeout, SHALL be ignored.
REQ-030 mgmt_rd_valid arriving in the same cycle as the timeout SHALL win: data is returned with err 0.
REQ-031 Strobe outputs SHALL be registered; address/data outputs SHALL hold their last value when idle.

Reset
REQ-032 rst SHALL force IDLE, all strobes/valids/ready to 0, err 0, data/address outputs to 0, the last-grant pointer to master 1 so master 0 wins first, and the counter to 0.
REQ-033 rst mid-transaction SHALL abandon it without a response pulse; the master reissues.

Structure
REQ-034 The FSM state enum and the TIMEOUT_DATA constant (0xFF) SHALL live in the shared management package.
REQ-035 The round-robin grant logic SHALL be a sub-module named mgmt_rr_arbiter_2.

Verification
REQ-036 Master 0 writes 0x5A to 0x0010 -> mgmt_wr_en for one cycle with addr 0x0010, data 0x5A; m_rsp_valid=01 two cycles after accept.
REQ-037 Master 1 reads 0x0004, slave answers 0x3C after 3 cycles -> m_rsp_valid=10, data 0x3C, err 0.
REQ-038 Both masters request continuously from reset -> grants alternate 0,1,0,1; never two strobes outstanding.
REQ-039 Read with no slave answer, TIMEOUT_CYCLES=8 -> response 8 cycles after mgmt_rd_en, data 0xFF, err 1; a later stray mgmt_rd_valid is ignored.
REQ-040 rst asserted in RD_WAIT -> next cycle IDLE, no m_rsp_valid, ready resumes with master 0 priority.
